// File: rtl/data_port_arbiter_if.sv
// data_port_arbiter_if: CPU and I/O request/response bundles plus the shared memory data port
//   cpu_req/we/addr/wd -> arbiter, cpu_gnt/rvalid/rd <- arbiter
//   io_req/we/addr/wd  -> arbiter, io_gnt/rvalid/rd  <- arbiter
//   addr_err           <- arbiter, pulse after a granted out-of-range access
//   mem_we/a/wd        <- arbiter towards memory, mem_rd -> arbiter from memory
//   master = requester/memory side, slave = arbiter side
interface data_port_arbiter_if #(parameter int WIDTH = 32);
   logic             cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [WIDTH-1:0] cpu_addr, cpu_wd, cpu_rd;
   logic             io_req, io_we, io_gnt, io_rvalid;
   logic [WIDTH-1:0] io_addr, io_wd, io_rd;
   logic             addr_err, mem_we;
   logic [WIDTH-1:0] mem_a, mem_wd, mem_rd;
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wd, io_req, io_we, io_addr, io_wd, mem_rd,
      input  cpu_gnt, cpu_rvalid, cpu_rd, io_gnt, io_rvalid, io_rd, addr_err, mem_we, mem_a, mem_wd
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wd, io_req, io_we, io_addr, io_wd, mem_rd,
      output cpu_gnt, cpu_rvalid, cpu_rd, io_gnt, io_rvalid, io_rd, addr_err, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/data_port_arbiter.sv
// data_port_arbiter: shares one memory data port between CPU (fixed priority) and I/O (starvation-protected)
//   clk   rising-edge clock
//   reset asynchronous active-high reset
//   bus   slave side of data_port_arbiter_if (requester handshakes, read returns, addr_err, memory port)
module data_port_arbiter #(
   parameter int WIDTH      = 32,
   parameter int MAX_WAIT   = 8,
   parameter int ADDR_LIMIT = 205
) (
   input  logic clk,
   input  logic reset,
   data_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, CPU_RD, IO_RD} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d, io_rd_q, io_rd_d;
   logic             addr_err_q, addr_err_d;
   logic             io_prio, io_gnt, cpu_gnt, any_gnt, sel_we, in_range;
   logic [WIDTH-1:0] sel_addr, sel_wd, rd_data;
   always_comb begin
      io_prio    = wait_cnt_q == CW'(MAX_WAIT);
      io_gnt     = bus.io_req & (~bus.cpu_req | io_prio);
      cpu_gnt    = bus.cpu_req & ~io_gnt;
      any_gnt    = io_gnt | cpu_gnt;
      sel_addr   = io_gnt ? bus.io_addr : cpu_gnt ? bus.cpu_addr : '0;
      sel_wd     = io_gnt ? bus.io_wd : cpu_gnt ? bus.cpu_wd : '0;
      sel_we     = io_gnt ? bus.io_we : cpu_gnt & bus.cpu_we;
      in_range   = sel_addr < WIDTH'(ADDR_LIMIT);
      // out-of-range reads return zero instead of whatever the memory drives
      rd_data    = in_range ? bus.mem_rd : '0;
      state_d    = (cpu_gnt & ~bus.cpu_we) ? CPU_RD : (io_gnt & ~bus.io_we) ? IO_RD : IDLE;
      cpu_rd_d   = (state_d == CPU_RD) ? rd_data : cpu_rd_q;
      io_rd_d    = (state_d == IO_RD) ? rd_data : io_rd_q;
      addr_err_d = any_gnt & ~in_range;
      wait_cnt_d = (io_gnt | ~bus.io_req) ? '0 : io_prio ? wait_cnt_q : wait_cnt_q + CW'(1);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         cpu_rd_q   <= '0;
         io_rd_q    <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         cpu_rd_q   <= cpu_rd_d;
         io_rd_q    <= io_rd_d;
         addr_err_q <= addr_err_d;
      end
   end
   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.io_gnt     = io_gnt;
   assign bus.mem_we     = sel_we & in_range;
   assign bus.mem_a      = sel_addr;
   assign bus.mem_wd     = sel_wd;
   assign bus.cpu_rvalid = state_q == CPU_RD;
   assign bus.io_rvalid  = state_q == IO_RD;
   assign bus.cpu_rd     = cpu_rd_q;
   assign bus.io_rd      = io_rd_q;
   assign bus.addr_err   = addr_err_q;
endmodule
